// File: rtl/lm32_icache_refill_pkg.sv
// Shared constants, FSM encoding and sizing helper for the instruction-cache refill master.
package lm32_icache_refill_pkg;

    localparam logic [2:0] LM32_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] LM32_CTI_BURST   = 3'b010;
    localparam logic [2:0] LM32_CTI_END     = 3'b111;
    localparam logic [1:0] LM32_BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        LM32_ICR_STATE_IDLE  = 2'd0,
        LM32_ICR_STATE_BURST = 2'd1,
        LM32_ICR_STATE_DONE  = 2'd2
    } icr_state_e;

    // Number of bits needed to hold value: floor(log2(value)) + 1.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lm32_icache_refill_if.sv
// Instruction-side Wishbone bus between the refill master and the bus slave.
interface lm32_icache_refill_if;

    // Handshake: a beat completes on a rising clock edge where i_cyc_o & i_stb_o are high
    // and the slave raises i_ack_i or i_err_i; until then the master holds i_adr_o/i_cti_o stable.
    logic [31:0] i_adr_o;
    logic        i_cyc_o;
    logic        i_stb_o;
    logic [2:0]  i_cti_o;
    logic [1:0]  i_bte_o;
    logic [3:0]  i_sel_o;
    logic        i_we_o;
    logic [31:0] i_dat_i;
    logic        i_ack_i;
    logic        i_err_i;

    modport master (
        output i_adr_o, i_cyc_o, i_stb_o, i_cti_o, i_bte_o, i_sel_o, i_we_o,
        input  i_dat_i, i_ack_i, i_err_i
    );

    modport slave (
        input  i_adr_o, i_cyc_o, i_stb_o, i_cti_o, i_bte_o, i_sel_o, i_we_o,
        output i_dat_i, i_ack_i, i_err_i
    );

endinterface

// File: rtl/lm32_icache_refill.sv
// Wishbone master that fetches one instruction-cache line as an incrementing burst
// and hands each word back to the cache with a one-cycle refill_ready strobe.
module lm32_icache_refill
    import lm32_icache_refill_pkg::*;
#(
    parameter int bytes_per_line = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 refill_request,
    input  logic [31:2]          refill_address,
    output logic                 refill_ready,
    output logic [31:0]          refill_data,
    output logic                 bus_error,
    output icr_state_e           o_state,
    lm32_icache_refill_if.master i_bus
);

    localparam int WORDS       = bytes_per_line / 4;
    localparam int words_width = clogb2(bytes_per_line) - 1 - 2;
    localparam int CNT_W       = (words_width == 0) ? 1 : words_width;

    localparam logic [31:0]      LINE_MASK  = 32'(bytes_per_line - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WORDS - 2);

    icr_state_e       r_state;
    icr_state_e       w_state_next;
    logic             r_req_q;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_adr;
    logic             r_cyc;
    logic [2:0]       r_cti;
    logic             r_ready;
    logic [31:0]      r_data;
    logic             r_bus_error;

    logic             w_start;
    logic             w_term;
    logic             w_last;
    logic             w_load;
    logic             w_beat;
    logic [31:0]      w_req_byte;

    assign w_start    = refill_request & ~r_req_q;
    assign w_term     = i_bus.i_ack_i | i_bus.i_err_i;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_req_byte = {refill_address, 2'b00};

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            LM32_ICR_STATE_IDLE: begin
                if (w_start) begin
                    w_load       = 1'b1;
                    w_state_next = LM32_ICR_STATE_BURST;
                end
            end
            LM32_ICR_STATE_BURST: begin
                if (w_term) begin
                    w_beat = 1'b1;
                    if (w_last) begin
                        w_state_next = LM32_ICR_STATE_DONE;
                    end
                end
            end
            LM32_ICR_STATE_DONE: w_state_next = LM32_ICR_STATE_IDLE;
            default:             w_state_next = LM32_ICR_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LM32_ICR_STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_q     <= 1'b0;
            r_cnt       <= '0;
            r_adr       <= 32'h0;
            r_cyc       <= 1'b0;
            r_cti       <= LM32_CTI_CLASSIC;
            r_ready     <= 1'b0;
            r_data      <= 32'h0;
            r_bus_error <= 1'b0;
        end else begin
            r_req_q <= refill_request;
            r_ready <= w_beat;
            if (w_load) begin
                r_adr       <= w_req_byte & ~LINE_MASK;
                r_cnt       <= '0;
                r_cyc       <= 1'b1;
                r_cti       <= (WORDS == 1) ? LM32_CTI_END : LM32_CTI_BURST;
                r_bus_error <= 1'b0;
            end
            // An error beat still returns a (zero) word so the cache always sees a full line.
            if (w_beat) begin
                r_data <= i_bus.i_err_i ? 32'h0 : i_bus.i_dat_i;
                if (i_bus.i_err_i) begin
                    r_bus_error <= 1'b1;
                end
                r_cnt <= r_cnt + 1'b1;
                r_adr <= (r_adr & ~LINE_MASK) | ((r_adr + 32'd4) & LINE_MASK);
                if (w_last) begin
                    r_cyc <= 1'b0;
                    r_cti <= LM32_CTI_CLASSIC;
                end else if ((WORDS > 1) && (r_cnt == CNT_PENULT)) begin
                    r_cti <= LM32_CTI_END;
                end
            end
        end
    end

    assign i_bus.i_adr_o = r_adr;
    assign i_bus.i_cyc_o = r_cyc;
    assign i_bus.i_stb_o = r_cyc;
    assign i_bus.i_cti_o = r_cti;
    assign i_bus.i_bte_o = LM32_BTE_LINEAR;
    assign i_bus.i_sel_o = 4'b1111;
    assign i_bus.i_we_o  = 1'b0;
    assign refill_ready  = r_ready;
    assign refill_data   = r_data;
    assign bus_error     = r_bus_error;
    assign o_state       = r_state;

endmodule

// File: tb/tb_lm32_icache_refill.sv
// Self-checking bench for lm32_icache_refill: a 16-byte-line and a 4-byte-line instance
// driven from a table of refill scenarios plus a hand-written reset-mid-burst sequence.
module tb_lm32_icache_refill;
    import lm32_icache_refill_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        use4 = 1'b0;
    logic [31:2] raddr = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [31:0] dat = 32'h0;

    logic        req16, req4;
    logic        ready16, ready4, berr16, berr4;
    logic [31:0] data16, data4;
    icr_state_e  state16, state4;

    logic        m_ready, m_berr, m_cyc, m_stb;
    logic [31:0] m_data, m_adr;
    logic [2:0]  m_cti;
    icr_state_e  m_state;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_err[2];

    always #5 clk = ~clk;

    lm32_icache_refill_if bus16();
    lm32_icache_refill_if bus4();

    assign bus16.i_dat_i = dat;
    assign bus16.i_ack_i = ack;
    assign bus16.i_err_i = err;
    assign bus4.i_dat_i  = dat;
    assign bus4.i_ack_i  = ack;
    assign bus4.i_err_i  = err;
    assign req16 = req & ~use4;
    assign req4  = req & use4;

    lm32_icache_refill #(.bytes_per_line(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .refill_request(req16), .refill_address(raddr),
        .refill_ready(ready16), .refill_data(data16), .bus_error(berr16),
        .o_state(state16), .i_bus(bus16)
    );

    lm32_icache_refill #(.bytes_per_line(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .refill_request(req4), .refill_address(raddr),
        .refill_ready(ready4), .refill_data(data4), .bus_error(berr4),
        .o_state(state4), .i_bus(bus4)
    );

    assign m_ready = use4 ? ready4 : ready16;
    assign m_data  = use4 ? data4 : data16;
    assign m_berr  = use4 ? berr4 : berr16;
    assign m_cyc   = use4 ? bus4.i_cyc_o : bus16.i_cyc_o;
    assign m_stb   = use4 ? bus4.i_stb_o : bus16.i_stb_o;
    assign m_adr   = use4 ? bus4.i_adr_o : bus16.i_adr_o;
    assign m_cti   = use4 ? bus4.i_cti_o : bus16.i_cti_o;
    assign m_state = use4 ? state4 : state16;

    typedef struct {
        bit          use4;
        logic [31:2] addr;
        int          wait_beat;
        int          wait_n;
        int          err_beat;
        bit          err_ack;
        int          hold;
        logic [31:0] exp_base;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cyc"},   32'(m_cyc), 32'd0);
        chk({tag, "_stb"},   32'(m_stb), 32'd0);
        chk({tag, "_cti"},   32'(m_cti), 32'd0);
        chk({tag, "_adr"},   m_adr, 32'h0);
        chk({tag, "_ready"}, 32'(m_ready), 32'd0);
        chk({tag, "_data"},  m_data, 32'h0);
        chk({tag, "_berr"},  32'(m_berr), 32'd0);
        chk({tag, "_state"}, 32'(m_state), 32'(LM32_ICR_STATE_IDLE));
    endtask

    // One refill: acts as the Wishbone slave and the cache-side monitor. Latency is the
    // number of falling edges from raising the request to seeing the last refill_ready.
    task automatic run_vec(input vec_t v);
        int          words;
        int          beat;
        int          waits;
        int          nready;
        int          lat;
        logic [31:0] d;
        logic [31:0] exp_adr;
        words  = v.use4 ? 1 : 4;
        beat   = 0;
        waits  = v.wait_n;
        nready = 0;
        lat    = -1;
        @(negedge clk);
        use4 = v.use4;
        #1;
        chk("err_held_before_start", 32'(m_berr), 32'(prev_err[v.use4]));
        chk("idle_before_start", 32'(m_cyc), 32'd0);
        raddr = v.addr;
        req = 1'b1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            ack = 1'b0;
            err = 1'b0;
            if (c == 1) chk("err_cleared_on_start", 32'(m_berr), 32'd0);
            if (m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("ready_extra", 32'd1, 32'd0);
                end else begin
                    d = exp_q.pop_front();
                    chk("refill_data", m_data, d);
                end
                nready++;
                if (nready == words) lat = c;
            end
            if (m_cyc && m_stb && beat < words) begin
                exp_adr = v.exp_base + 32'(4 * beat);
                chk("adr", m_adr, exp_adr);
                chk("cti", 32'(m_cti), (beat == words - 1) ? 32'(LM32_CTI_END) : 32'(LM32_CTI_BURST));
                if (beat == v.wait_beat && waits > 0) begin
                    waits--;
                end else begin
                    d   = $urandom;
                    dat = d;
                    if (beat == v.err_beat) begin
                        err = 1'b1;
                        ack = v.err_ack;
                        exp_q.push_back(32'h0);
                    end else begin
                        ack = 1'b1;
                        exp_q.push_back(d);
                    end
                    beat++;
                end
            end
        end
        if (lat < 0) chk("refill_timeout", 32'd1, 32'd0);
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("ready_count", 32'(nready), 32'(words));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("bus_error", 32'(m_berr), 32'(v.exp_err));
        chk("cyc_dropped", 32'(m_cyc), 32'd0);
        exp_q.delete();
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("no_refetch_cyc", 32'(m_cyc), 32'd0);
            chk("no_refetch_ready", 32'(m_ready), 32'd0);
            chk("err_held_after", 32'(m_berr), 32'(v.exp_err));
        end
        @(negedge clk);
        req = 1'b0;
        chk("quiet_ready", 32'(m_ready), 32'd0);
        chk("quiet_state", 32'(m_state), 32'(LM32_ICR_STATE_IDLE));
        prev_err[v.use4] = v.exp_err;
    endtask

    initial begin
        logic [31:0] d0, d1, d2;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d0, d1, d2;

        vecs[0] = '{use4:1'b0, addr:30'h0000_0405, wait_beat:-1, wait_n:0, err_beat:-1, err_ack:1'b0,
                    hold:0, exp_base:32'h0000_1010, exp_lat:5, exp_err:1'b0};
        vecs[1] = '{use4:1'b0, addr:30'h0000_0405, wait_beat:1, wait_n:3, err_beat:-1, err_ack:1'b0,
                    hold:0, exp_base:32'h0000_1010, exp_lat:8, exp_err:1'b0};
        vecs[2] = '{use4:1'b0, addr:30'h0000_2003, wait_beat:-1, wait_n:0, err_beat:0, err_ack:1'b0,
                    hold:0, exp_base:32'h0000_8000, exp_lat:5, exp_err:1'b1};
        vecs[3] = '{use4:1'b0, addr:30'h0000_040F, wait_beat:-1, wait_n:0, err_beat:-1, err_ack:1'b0,
                    hold:2, exp_base:32'h0000_1030, exp_lat:5, exp_err:1'b0};
        vecs[4] = '{use4:1'b0, addr:30'h3FFF_FFFF, wait_beat:-1, wait_n:0, err_beat:2, err_ack:1'b1,
                    hold:0, exp_base:32'hFFFF_FFF0, exp_lat:5, exp_err:1'b1};
        vecs[5] = '{use4:1'b1, addr:30'h0000_0802, wait_beat:-1, wait_n:0, err_beat:-1, err_ack:1'b0,
                    hold:0, exp_base:32'h0000_2008, exp_lat:2, exp_err:1'b0};
        vecs[6] = '{use4:1'b1, addr:30'h0000_1234, wait_beat:-1, wait_n:0, err_beat:0, err_ack:1'b0,
                    hold:1, exp_base:32'h0000_48D0, exp_lat:2, exp_err:1'b1};
        vecs[7] = '{use4:1'b0, addr:30'h0ABC_DEF7, wait_beat:3, wait_n:2, err_beat:-1, err_ack:1'b0,
                    hold:0, exp_base:32'h2AF3_7BD0, exp_lat:7, exp_err:1'b0};
        prev_err[0] = 1'b0;
        prev_err[1] = 1'b0;

        repeat (3) @(negedge clk);
        use4 = 1'b0;
        #1;
        check_idle_outputs("rst16");
        use4 = 1'b1;
        #1;
        check_idle_outputs("rst4");
        chk("bte16", 32'(bus16.i_bte_o), 32'd0);
        chk("sel16", 32'(bus16.i_sel_o), 32'hF);
        chk("we16",  32'(bus16.i_we_o), 32'd0);
        chk("sel4",  32'(bus4.i_sel_o), 32'hF);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Reset lands on the same edge as the beat-2 acknowledge.
        d0 = $urandom;
        d1 = $urandom;
        d2 = $urandom;
        @(negedge clk);
        use4 = 1'b0;
        #1;
        raddr = 30'h0000_0405;
        req = 1'b1;
        @(negedge clk);
        chk("rstseq_cyc", 32'(m_cyc), 32'd1);
        ack = 1'b1;
        dat = d0;
        @(negedge clk);
        chk("rstseq_ready0", 32'(m_ready), 32'd1);
        chk("rstseq_data0", m_data, d0);
        dat = d1;
        @(negedge clk);
        chk("rstseq_ready1", 32'(m_ready), 32'd1);
        chk("rstseq_data1", m_data, d1);
        chk("rstseq_adr2", m_adr, 32'h0000_1018);
        dat = d2;
        rst = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_idle_outputs("rstseq");
        rst = 1'b0;
        req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstseq_quiet_ready", 32'(m_ready), 32'd0);
            chk("rstseq_quiet_cyc", 32'(m_cyc), 32'd0);
        end
        prev_err[0] = 1'b0;
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
